// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise logic stage with valid/ready handshakes,
// a two-entry output skid buffer and an accepted-transaction counter.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid_y;
  logic [WIDTH-1:0] res;
  logic             accept;
  logic             consume;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // Bitwise op select; every code is defined.
  always_comb begin
    res = '0;
    case (in_op)
      3'd0: res = ~in_a;
      3'd1: res = in_a;
      3'd2: res = in_a & in_b;
      3'd3: res = in_a | in_b;
      3'd4: res = in_a ^ in_b;
      3'd5: res = ~(in_a & in_b);
      3'd6: res = ~(in_a | in_b);
      3'd7: res = ~(in_a ^ in_b);
      default: res = '0;
    endcase
  end

  // Occupancy FSM: head register drives the outputs, skid holds the second result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_y     <= '0;
      out_zero  <= 1'b0;
      skid_y    <= '0;
      op_count  <= '0;
    end else begin
      if (accept) op_count <= op_count + CNT_W'(1);
      case (state)
        EMPTY: begin
          if (accept) begin
            out_y     <= res;
            out_zero  <= (res == '0);
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            out_y    <= res;
            out_zero <= (res == '0);
          end else if (accept) begin
            skid_y   <= res;
            in_ready <= 1'b0;
            state    <= TWO;
          end else if (consume) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            out_y    <= skid_y;
            out_zero <= (skid_y == '0);
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboarded random bench for logic_unit_pipe; a CNT_W=4 copy shares the
// stimulus so counter wrap is observed alongside the 16-bit counter.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_y;
  logic        out_zero;
  logic [15:0] op_count;

  logic        in_ready4;
  logic        out_valid4;
  logic [7:0]  out_y4;
  logic        out_zero4;
  logic [3:0]  op_count4;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero), .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid4),
    .out_ready(out_ready), .out_y(out_y4), .out_zero(out_zero4), .op_count(op_count4)
  );

  typedef struct {
    logic [7:0] y;
    logic       z;
    int         cyc;
    bit         lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   count_model = 0;
  int   pops = 0;
  bit   lat_mode = 1'b0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: per-bit truth table indexed by {a,b}.
  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    logic [3:0] tt;
    logic [7:0] y;
    case (op)
      3'd0: tt = 4'b0011;
      3'd1: tt = 4'b1100;
      3'd2: tt = 4'b1000;
      3'd3: tt = 4'b1110;
      3'd4: tt = 4'b0110;
      3'd5: tt = 4'b0111;
      3'd6: tt = 4'b0001;
      default: tt = 4'b1001;
    endcase
    for (int i = 0; i < 8; i++) y[i] = tt[{a[i], b[i]}];
    return y;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops on every output handshake and checks stall stability.
  logic [7:0] prev_y;
  bit         prev_stall = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_y", 32'(out_y), 32'(prev_y));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none at cycle %0d", out_y, cyc);
        end else begin
          e = q.pop_front();
          chk("out_y", 32'(out_y), 32'(e.y));
          chk("out_zero", 32'(out_zero), 32'(e.z));
          if (e.lat) chk("latency", 32'(cyc), 32'(e.cyc + 1));
          pops++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [7:0] exp_y);
    exp_t e;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.y = exp_y; e.z = (exp_y == 8'h00); e.cyc = cyc; e.lat = lat_mode;
        q.push_back(e);
        count_model++;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout actual=in_ready_low required=accept at cycle %0d", cyc);
  endtask

  task automatic send_rand();
    logic [7:0] a, b;
    logic [2:0] op;
    a  = 8'($urandom);
    b  = 8'($urandom);
    op = 3'($urandom);
    send(a, b, op, model(a, b, op));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    in_op    = 3'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 200 && q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_counts();
    chk("op_count16", 32'(op_count), 32'(count_model % 65536));
    chk("op_count4", 32'(op_count4), 32'(count_model % 16));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    count_model = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk_counts();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp2 [8];
    logic [7:0] a3, b3;
    logic [2:0] op3;
    int         pops0;
    int         stop;
    exp2 = '{8'h0F, 8'hF0, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    do_reset();

    // Fixed operands through every op, then the zero flag.
    out_ready = 1'b1;
    lat_mode  = 1'b1;
    for (int op = 0; op < 8; op++) send(8'hF0, 8'hCC, 3'(op), exp2[op]);
    send(8'hA5, 8'hA5, 3'd4, 8'h00);
    drain();
    chk_counts();

    // Backpressure: two accepted, third blocked until the consumer frees space.
    lat_mode  = 1'b0;
    out_ready = 1'b0;
    send_rand();
    send_rand();
    a3 = 8'($urandom); b3 = 8'($urandom); op3 = 3'($urandom);
    in_valid = 1'b1; in_a = a3; in_b = b3; in_op = op3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(a3, b3, op3, model(a3, b3, op3));
    drain();
    chk_counts();

    // Reset in the middle of traffic with a full buffer.
    out_ready = 1'b0;
    send_rand();
    send_rand();
    do_reset();

    // Full-rate stream.
    out_ready = 1'b1;
    lat_mode  = 1'b1;
    pops0     = pops;
    for (int i = 0; i < 100; i++) send_rand();
    drain();
    chk("stream_pops", 32'(pops - pops0), 32'd100);
    chk("stream_count", 32'(op_count), 32'd100);
    chk_counts();

    // Counter wrap on the 4-bit copy.
    lat_mode = 1'b0;
    do_reset();
    for (int i = 0; i < 17; i++) send_rand();
    drain();
    chk("wrap_count4", 32'(op_count4), 32'd1);
    chk_counts();

    // Random stall mix.
    pops0      = pops;
    rand_ready = 1'b1;
    stop       = cyc + 10000;
    while (cyc < stop) begin
      if ($urandom_range(0, 3) != 0) send_rand();
      else idle();
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    chk("mix_pops", 32'(pops - pops0), 32'(count_model - 17));
    chk_counts();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
